// File: rtl/calc_pkg.sv
// Shared definitions for the calculator sequencer: instruction layout, opcodes, NOP word, FSM states.
package calc_pkg;

  localparam int INSTR_W  = 11;
  localparam int CTRL_LSB = 8;
  localparam int CTRL_W   = 3;
  localparam int IMM_LSB  = 4;
  localparam int IMM_W    = 4;
  localparam int RD_LSB   = 2;
  localparam int WE_LSB   = 0;
  localparam int REG_W    = 2;

  localparam logic [CTRL_W-1:0] OP_AND = 3'b000;
  localparam logic [CTRL_W-1:0] OP_ADD = 3'b010;
  localparam logic [CTRL_W-1:0] OP_SUB = 3'b110;
  localparam logic [CTRL_W-1:0] OP_SLT = 3'b111;

  typedef struct packed {
    logic [CTRL_W-1:0] control;
    logic [IMM_W-1:0]  immediate;
    logic [REG_W-1:0]  rd_addr;
    logic [REG_W-1:0]  we_addr;
  } instr_t;

  // r0 = r0 + 0: leaves the calculator state untouched
  localparam logic [INSTR_W-1:0] NOP_WORD = {OP_ADD, 4'd0, 2'd0, 2'd0};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic instr_t decode(input logic [INSTR_W-1:0] w);
    instr_t i;
    i.control   = w[CTRL_LSB +: CTRL_W];
    i.immediate = w[IMM_LSB +: IMM_W];
    i.rd_addr   = w[RD_LSB +: REG_W];
    i.we_addr   = w[WE_LSB +: REG_W];
    return i;
  endfunction

endpackage

// File: rtl/calc_prog_mem.sv
// Program store: synchronous write, asynchronous read, no reset so a loaded program survives rst_n.
module calc_prog_mem #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int DATA_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/calc_sequencer.sv
// Streams a stored program to the calculator, one instruction per cycle with no stalls;
// NOP is presented outside RUN, done pulses for one cycle at the end of each run.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int PROG_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        prog_we,
  input  logic [3:0]  prog_addr,
  input  logic [10:0] prog_data,
  input  logic        start,
  input  logic [4:0]  len,
  output logic [2:0]  calc_control,
  output logic [3:0]  calc_immediate,
  output logic [1:0]  calc_rd_addr,
  output logic [1:0]  calc_we_addr,
  input  logic [3:0]  calc_rd_data,
  output logic        busy,
  output logic        done,
  output logic [3:0]  pc,
  output logic [3:0]  result
);

  localparam logic [4:0] MAX_LEN = 5'(PROG_DEPTH);

  state_t             state_q, state_nxt;
  logic [4:0]         len_q;
  logic [4:0]         len_clamped;
  logic               last_issue;
  logic               mem_we;
  logic [INSTR_W-1:0] instr_word;
  instr_t             cur_instr, out_instr;

  assign len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign last_issue  = ({1'b0, pc} == (len_q - 5'd1));
  assign mem_we      = prog_we && (state_q == ST_IDLE);

  calc_prog_mem #(
    .DEPTH  (PROG_DEPTH),
    .ADDR_W (4),
    .DATA_W (INSTR_W)
  ) u_prog_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc),
    .rdata (instr_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE: if (start) state_nxt = (len_clamped == 5'd0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (last_issue) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // pc holds on the final issue so it never wraps past the last entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= 4'd0;
      len_q  <= 5'd0;
      result <= 4'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pc    <= 4'd0;
            len_q <= len_clamped;
          end
        end
        ST_RUN: begin
          result <= calc_rd_data;
          if (!last_issue) pc <= pc + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign cur_instr = decode(instr_word);

  always_comb begin
    out_instr = decode(NOP_WORD);
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_RUN: begin
        out_instr = cur_instr;
        busy      = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign calc_control   = out_instr.control;
  assign calc_immediate = out_instr.immediate;
  assign calc_rd_addr   = out_instr.rd_addr;
  assign calc_we_addr   = out_instr.we_addr;

endmodule

// File: tb/tb_calc_sequencer.sv
// Directed bench for calc_sequencer with a tiny 4-register calculator attached and a queue scoreboard.
module tb_calc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_addr = 4'd0;
  logic [10:0] prog_data = 11'd0;
  logic        start = 1'b0;
  logic [4:0]  len = 5'd0;
  logic [2:0]  calc_control;
  logic [3:0]  calc_immediate;
  logic [1:0]  calc_rd_addr;
  logic [1:0]  calc_we_addr;
  logic [3:0]  calc_rd_data;
  logic        busy;
  logic        done;
  logic [3:0]  pc;
  logic [3:0]  result;

  localparam logic [10:0] NOP = 11'b010_0000_00_00;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;
  logic [14:0] issue_q [$];
  logic [3:0]  res_q [$];
  logic [10:0] img [16];
  logic [10:0] calc_word;

  assign calc_word = {calc_control, calc_immediate, calc_rd_addr, calc_we_addr};

  calc_sequencer #(.PROG_DEPTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .prog_we        (prog_we),
    .prog_addr      (prog_addr),
    .prog_data      (prog_data),
    .start          (start),
    .len            (len),
    .calc_control   (calc_control),
    .calc_immediate (calc_immediate),
    .calc_rd_addr   (calc_rd_addr),
    .calc_we_addr   (calc_we_addr),
    .calc_rd_data   (calc_rd_data),
    .busy           (busy),
    .done           (done),
    .pc             (pc),
    .result         (result)
  );

  always #5 clk = ~clk;

  // Calculator: rf[we] <= rf[rd] op imm every cycle, rd_data = rf[rd]
  logic signed [3:0] rf [4] = '{default: 4'sd0};
  assign calc_rd_data = rf[calc_rd_addr];

  function automatic logic [3:0] alu(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'b000:  return a & b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
      default: return a;
    endcase
  endfunction

  always @(posedge clk) rf[calc_we_addr] <= alu(calc_control, calc_rd_data, calc_immediate);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every cycle out of reset, either an expected issue or a NOP must be on the bus
  always @(negedge clk) begin
    logic [14:0] e;
    if (rst_n) begin
      if (busy) begin
        if (issue_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_issue actual pc=%0d word=%0h required=no issue", pc, calc_word);
        end else begin
          e = issue_q.pop_front();
          check("issue_pc", 32'(pc), 32'(e[14:11]));
          check("issue_word", 32'(calc_word), 32'(e[10:0]));
        end
      end else begin
        check("idle_nop", 32'(calc_word), 32'(NOP));
      end
      if (done) begin
        done_cnt++;
        check("done_width", 32'(prev_done), 32'd0);
        if (res_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0");
        end else begin
          check("result", 32'(result), 32'(res_q.pop_front()));
        end
      end
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  task automatic wr(input logic [3:0] a, input logic [10:0] d);
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    img[a] = d;
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  task automatic push_run(input int n);
    for (int i = 0; i < n; i++) issue_q.push_back({4'(i), img[i]});
  endtask

  task automatic go(input logic [4:0] l);
    @(posedge clk); #1;
    start = 1'b1; len = l;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0);
    for (int k = 0; k < 200 && done_cnt == n0; k++) @(negedge clk);
    #1;
    checks++;
    if (done_cnt == n0) begin
      failures++;
      $display("FAIL done_timeout actual=no done required=done within 200 cycles");
    end
    check("issue_q_drained", 32'(issue_q.size()), 32'd0);
    issue_q.delete();
    res_q.delete();
  endtask

  initial begin
    int n0;

    // Reset state
    #12;
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_nop", 32'(calc_word), 32'(NOP));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // ADD 2 r0->r0; SUB -2 r0->r1; AND 1 r1->r2; ADD 0 r2->r2 : reads 0,2,4,0
    wr(4'd0, {3'b010, 4'd2, 2'd0, 2'd0});
    wr(4'd1, {3'b110, 4'hE, 2'd0, 2'd1});
    wr(4'd2, {3'b000, 4'd1, 2'd1, 2'd2});
    wr(4'd3, {3'b010, 4'd0, 2'd2, 2'd2});
    n0 = done_cnt; push_run(4); res_q.push_back(4'd0);
    go(5'd4);
    wait_done(n0);

    // r1=4: SLT 7 r1->r3 gives 1, then read r3
    wr(4'd0, {3'b111, 4'd7, 2'd1, 2'd3});
    wr(4'd1, {3'b010, 4'd0, 2'd3, 2'd3});
    n0 = done_cnt; push_run(2); res_q.push_back(4'd1);
    go(5'd2);
    wait_done(n0);

    // r2=0, r2=-8, SLT 7 r2->r0 gives 1, read r0
    wr(4'd0, {3'b000, 4'd0, 2'd2, 2'd2});
    wr(4'd1, {3'b010, 4'h8, 2'd2, 2'd2});
    wr(4'd2, {3'b111, 4'd7, 2'd2, 2'd0});
    wr(4'd3, {3'b010, 4'd0, 2'd0, 2'd0});
    n0 = done_cnt; push_run(4); res_q.push_back(4'd1);
    go(5'd4);
    wait_done(n0);

    // len=0: straight to DONE, result unchanged
    n0 = done_cnt; res_q.push_back(4'd1);
    go(5'd0);
    check("len0_done", 32'(done), 32'd1);
    check("len0_busy", 32'(busy), 32'd0);
    wait_done(n0);

    // 8-entry program ending with r0=4 read; reset mid-run then replay
    wr(4'd0, {3'b000, 4'd0, 2'd0, 2'd0});
    wr(4'd1, {3'b010, 4'd3, 2'd0, 2'd1});
    wr(4'd2, {3'b010, 4'd1, 2'd1, 2'd1});
    wr(4'd3, {3'b110, 4'd1, 2'd1, 2'd2});
    wr(4'd4, {3'b111, 4'd4, 2'd2, 2'd3});
    wr(4'd5, {3'b010, 4'd2, 2'd3, 2'd3});
    wr(4'd6, {3'b110, 4'hF, 2'd3, 2'd0});
    wr(4'd7, {3'b010, 4'd0, 2'd0, 2'd0});
    push_run(2);
    go(5'd8);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_pc", 32'(pc), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_result", 32'(result), 32'd0);
    check("midrst_nop", 32'(calc_word), 32'(NOP));
    check("midrst_partial_issues", 32'(issue_q.size()), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n0 = done_cnt; push_run(8); res_q.push_back(4'd4);
    go(5'd8);
    wait_done(n0);

    // Full 16-entry run with distinct immediates; start/prog_we pulsed mid-run
    wr(4'd0, {3'b000, 4'd0, 2'd0, 2'd0});
    for (int i = 1; i < 16; i++) wr(4'(i), {3'b010, 4'(i), 2'd0, 2'd1});
    n0 = done_cnt; push_run(16); res_q.push_back(4'd0);
    go(5'd16);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; len = 5'd1; prog_we = 1'b1; prog_addr = 4'd5; prog_data = 11'h7FF;
    @(posedge clk); #1;
    start = 1'b0; prog_we = 1'b0;
    wait_done(n0);

    // len above 16 clamps; re-run without reload also shows entry 5 untouched
    n0 = done_cnt; push_run(16); res_q.push_back(4'd0);
    go(5'd31);
    wait_done(n0);

    // Write entry 0 and start together: new SUB 1 r1->r3 issued, reads r1=-1
    n0 = done_cnt;
    img[0] = {3'b110, 4'd1, 2'd1, 2'd3};
    push_run(1); res_q.push_back(4'hF);
    @(posedge clk); #1;
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = img[0]; start = 1'b1; len = 5'd1;
    @(posedge clk); #1;
    prog_we = 1'b0; start = 1'b0;
    wait_done(n0);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
